fetch_unit: RTL and testbench



---
 rtl/riscv_pkg.sv | 41 ++++
 rtl/pc_next.sv | 27 ++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I monocycle core front end: fetch
// states, the canonical NOP, opcode constants and instruction field
// bit positions.
package riscv_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    TRAP  = 2'b10
  } fetch_state_e;

  // addi x0,x0,0 -- held in the instruction register when nothing valid
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Base opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction field bit positions
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 or the branch/jump target with
// bit 0 cleared (jalr rule), plus a flag for a target that is not
// word aligned.
module pc_next
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] PC,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] ALURes,
  output logic [XLEN-1:0] NextPC,
  output logic [XLEN-1:0] PCInc,
  output logic            Misaligned
);

  logic [XLEN-1:0] target;

  // Target selection and alignment check; PC+4 wraps naturally
  always_comb begin
    PCInc      = PC + XLEN'(4);
    target     = ALURes & ~{{(XLEN-1){1'b0}}, 1'b1};
    NextPC     = NextPCSrc ? target : PCInc;
    Misaligned = NextPCSrc & target[1];
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a valid
// handshake, presents decoded fields, and traps on misaligned targets.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            NextPCSrc,
  input  logic [XLEN-1:0] ALURes,
  output logic [XLEN-1:0] IMemAddr,
  output logic            IMemReq,
  input  logic            IMemValid,
  input  logic [31:0]     IMemRData,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCInc,
  output logic [31:0]     Instr,
  output logic [6:0]      Opcode,
  output logic [2:0]      Function3,
  output logic [6:0]      Function7,
  output logic [4:0]      Rs1,
  output logic [4:0]      Rs2,
  output logic [4:0]      Rd,
  output logic            InstrValid,
  output logic            Trap,
  output logic [XLEN-1:0] TrapAddr
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] trapAddr_q, trapAddr_d;

  logic [XLEN-1:0] nextPc;
  logic            misaligned;

  pc_next #(.XLEN(XLEN)) u_pc_next (
    .PC         (pc_q),
    .NextPCSrc  (NextPCSrc),
    .ALURes     (ALURes),
    .NextPC     (nextPc),
    .PCInc      (PCInc),
    .Misaligned (misaligned)
  );

  // State and datapath registers; reset beats any in-flight fetch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      trap_q     <= 1'b0;
      trapAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      trap_q     <= trap_d;
      trapAddr_q <= trapAddr_d;
    end
  end

  // Next-state logic: capture in FETCH, advance or trap in EXEC, park in TRAP
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    trap_d     = trap_q;
    trapAddr_d = trapAddr_q;
    case (state_q)
      FETCH: begin
        if (IMemValid) begin
          instr_d = IMemRData;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (misaligned) begin
          trap_d     = 1'b1;
          trapAddr_d = nextPc;
          state_d    = TRAP;
        end else begin
          pc_d    = nextPc;
          state_d = FETCH;
        end
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Handshake, strobe and decoded-field outputs
  always_comb begin
    IMemReq    = (state_q == FETCH);
    InstrValid = (state_q == EXEC);
    IMemAddr   = pc_q;
    PC         = pc_q;
    Instr      = instr_q;
    Trap       = trap_q;
    TrapAddr   = trapAddr_q;
    Opcode     = instr_q[OPCODE_MSB:OPCODE_LSB];
    Rd         = instr_q[RD_MSB:RD_LSB];
    Function3  = instr_q[FUNCT3_MSB:FUNCT3_LSB];
    Rs1        = instr_q[RS1_MSB:RS1_LSB];
    Rs2        = instr_q[RS2_MSB:RS2_LSB];
    Function7  = instr_q[FUNCT7_MSB:FUNCT7_LSB];
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expected values.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] WORD_A = 32'h0050_0093;
   localparam logic [31:0] WORD_B = 32'h0020_8133;
   localparam logic [31:0] WORD_C = 32'h0040_A183;

   logic        clk;
   logic        rst_n;
   logic        NextPCSrc;
   logic [31:0] ALURes;
   logic [31:0] IMemAddr;
   logic        IMemReq;
   logic        IMemValid;
   logic [31:0] IMemRData;
   logic [31:0] PC;
   logic [31:0] PCInc;
   logic [31:0] Instr;
   logic [6:0]  Opcode;
   logic [2:0]  Function3;
   logic [6:0]  Function7;
   logic [4:0]  Rs1;
   logic [4:0]  Rs2;
   logic [4:0]  Rd;
   logic        InstrValid;
   logic        Trap;
   logic [31:0] TrapAddr;

   int checkCount;
   int passCount;

   fetch_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .NextPCSrc  (NextPCSrc),
      .ALURes     (ALURes),
      .IMemAddr   (IMemAddr),
      .IMemReq    (IMemReq),
      .IMemValid  (IMemValid),
      .IMemRData  (IMemRData),
      .PC         (PC),
      .PCInc      (PCInc),
      .Instr      (Instr),
      .Opcode     (Opcode),
      .Function3  (Function3),
      .Function7  (Function7),
      .Rs1        (Rs1),
      .Rs2        (Rs2),
      .Rd         (Rd),
      .InstrValid (InstrValid),
      .Trap       (Trap),
      .TrapAddr   (TrapAddr)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expectation and tally it
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
   endtask

   // Drive one cycle of inputs, clock it in, then settle past the edge
   task automatic applyStimulus(input logic rstn, input logic valid,
                                input logic [31:0] rdata, input logic src,
                                input logic [31:0] alu);
      rst_n     = rstn;
      IMemValid = valid;
      IMemRData = rdata;
      NextPCSrc = src;
      ALURes    = alu;
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence
   initial begin
      checkCount = 0;
      passCount  = 0;

      // Reset with a valid word present: reset must win
      applyStimulus(1'b0, 1'b1, WORD_B, 1'b0, 32'h0);
      checkOutput("rst_pc", PC, 32'h0);
      checkOutput("rst_instr", Instr, NOP);
      checkOutput("rst_ivalid", {31'b0, InstrValid}, 32'h0);
      checkOutput("rst_trap", {31'b0, Trap}, 32'h0);
      checkOutput("rst_trapaddr", TrapAddr, 32'h0);
      checkOutput("rst_req", {31'b0, IMemReq}, 32'h1);
      checkOutput("rst_addr", IMemAddr, 32'h0);

      // Zero-wait fetch of A at 0
      applyStimulus(1'b1, 1'b1, WORD_A, 1'b0, 32'h0);
      checkOutput("a_ivalid", {31'b0, InstrValid}, 32'h1);
      checkOutput("a_instr", Instr, WORD_A);
      checkOutput("a_opcode", {25'b0, Opcode}, 32'h13);
      checkOutput("a_rd", {27'b0, Rd}, 32'h1);
      checkOutput("a_req", {31'b0, IMemReq}, 32'h0);
      checkOutput("a_pcinc", PCInc, 32'h4);

      // EXEC with sequential PC; stray valid must be ignored
      applyStimulus(1'b1, 1'b1, WORD_C, 1'b0, 32'h0);
      checkOutput("seq_addr4", IMemAddr, 32'h4);
      checkOutput("seq_req4", {31'b0, IMemReq}, 32'h1);
      checkOutput("seq_ivalid4", {31'b0, InstrValid}, 32'h0);
      checkOutput("seq_hold_a", Instr, WORD_A);

      // Three wait cycles at PC=4
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0);
         checkOutput("wait_req", {31'b0, IMemReq}, 32'h1);
         checkOutput("wait_addr", IMemAddr, 32'h4);
         checkOutput("wait_ivalid", {31'b0, InstrValid}, 32'h0);
         checkOutput("wait_hold", Instr, WORD_A);
      end
      applyStimulus(1'b1, 1'b1, WORD_B, 1'b0, 32'h0);
      checkOutput("b_ivalid", {31'b0, InstrValid}, 32'h1);
      checkOutput("b_instr", Instr, WORD_B);
      checkOutput("b_opcode", {25'b0, Opcode}, 32'h33);
      checkOutput("b_rd", {27'b0, Rd}, 32'h2);
      checkOutput("b_rs1", {27'b0, Rs1}, 32'h1);
      checkOutput("b_rs2", {27'b0, Rs2}, 32'h2);

      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("seq_addr8", IMemAddr, 32'h8);

      // Fetch C at 8, then branch to 0x40
      applyStimulus(1'b1, 1'b1, WORD_C, 1'b0, 32'h0);
      checkOutput("c_instr", Instr, WORD_C);
      checkOutput("c_opcode", {25'b0, Opcode}, 32'h03);
      checkOutput("c_rd", {27'b0, Rd}, 32'h3);
      checkOutput("c_f3", {29'b0, Function3}, 32'h2);
      checkOutput("c_pcinc", PCInc, 32'hC);
      checkOutput("c_pc", PC, 32'h8);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
      checkOutput("br_addr", IMemAddr, 32'h40);

      // jalr-style odd target clears bit 0
      applyStimulus(1'b1, 1'b1, WORD_A, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0101);
      checkOutput("jalr_addr", IMemAddr, 32'h100);
      checkOutput("jalr_notrap", {31'b0, Trap}, 32'h0);

      // Misaligned target traps
      applyStimulus(1'b1, 1'b1, 32'h0000_8067, 1'b0, 32'h0);
      checkOutput("jalr_f7", {25'b0, Function7}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0106);
      checkOutput("trap_flag", {31'b0, Trap}, 32'h1);
      checkOutput("trap_addr", TrapAddr, 32'h106);
      checkOutput("trap_pc", PC, 32'h100);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'b1, WORD_A, 1'b0, 32'h0);
         checkOutput("trap_req", {31'b0, IMemReq}, 32'h0);
         checkOutput("trap_ivalid", {31'b0, InstrValid}, 32'h0);
      end
      checkOutput("trap_sticky", {31'b0, Trap}, 32'h1);

      // Reset leaves the trap and refetches RESET_PC
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("unrst_trap", {31'b0, Trap}, 32'h0);
      checkOutput("unrst_req", {31'b0, IMemReq}, 32'h1);
      checkOutput("unrst_addr", IMemAddr, 32'h0);

      // Reach a FETCH wait at 0x20, then reset with a late valid
      applyStimulus(1'b1, 1'b1, WORD_A, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h20);
      checkOutput("w20_addr", IMemAddr, 32'h20);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, WORD_C, 1'b0, 32'h0);
      checkOutput("mid_pc", PC, 32'h0);
      checkOutput("mid_instr", Instr, NOP);
      checkOutput("mid_req", {31'b0, IMemReq}, 32'h1);
      checkOutput("mid_ivalid", {31'b0, InstrValid}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("late_ivalid", {31'b0, InstrValid}, 32'h0);
      checkOutput("late_instr", Instr, NOP);

      // PC wraps from 0xFFFF_FFFC to 0 without trapping
      applyStimulus(1'b1, 1'b1, WORD_A, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      checkOutput("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
      applyStimulus(1'b1, 1'b1, WORD_B, 1'b0, 32'h0);
      checkOutput("wrap_pcinc", PCInc, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wrap_next", IMemAddr, 32'h0);
      checkOutput("wrap_notrap", {31'b0, Trap}, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
